matrix_cmd_seq: RTL and testbench

- Command-side sequencer that drives the matrix stack controller's load/push/pop/load-identity inputs from the host command stream.
- Accepts decoded matrix commands plus a 32-bit float word stream.
- Assembles the 16 words of a glLoadMatrix into four 128-bit rows, then issues them back-to-back in the exact 4-cycle burst the stack expects. Single-cycle commands are converted into one-cycle enable pulses.
- Sits between the command decoder FIFO and the matrix stack.

---
 rtl/matrix_pkg.sv | 43 ++++
 rtl/matrix_row_buffer.sv | 52 +++++
 rtl/matrix_cmd_seq.sv | 136 +++++++++++++
 tb/tb_matrix_cmd_seq.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix command sequencer and the matrix stack:
// command opcodes, mode values, row geometry, identity rows and the
// sequencer state encoding.
package matrix_pkg;

   localparam int ROW_W = 128;

   localparam logic [2:0] OP_NOP     = 3'd0;
   localparam logic [2:0] OP_LOAD    = 3'd1;
   localparam logic [2:0] OP_LOAD_ID = 3'd2;
   localparam logic [2:0] OP_PUSH    = 3'd3;
   localparam logic [2:0] OP_POP     = 3'd4;

   localparam logic MODE_MODELVIEW  = 1'b0;
   localparam logic MODE_PROJECTION = 1'b1;

   localparam logic [31:0] FLOAT_ONE = 32'h3F80_0000;

   // Identity rows, column 0 in the top word.
   localparam logic [ROW_W-1:0] ID_ROW0 = {FLOAT_ONE, 32'h0, 32'h0, 32'h0};
   localparam logic [ROW_W-1:0] ID_ROW1 = {32'h0, FLOAT_ONE, 32'h0, 32'h0};
   localparam logic [ROW_W-1:0] ID_ROW2 = {32'h0, 32'h0, FLOAT_ONE, 32'h0};
   localparam logic [ROW_W-1:0] ID_ROW3 = {32'h0, 32'h0, 32'h0, FLOAT_ONE};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_BURST   = 2'd2,
      ST_PULSE   = 2'd3
   } seq_state_t;

   function automatic logic [ROW_W-1:0] identity_row(input logic [1:0] r);
      logic [ROW_W-1:0] row;
      case (r)
         2'd0:    row = ID_ROW0;
         2'd1:    row = ID_ROW1;
         2'd2:    row = ID_ROW2;
         default: row = ID_ROW3;
      endcase
      return row;
   endfunction

endpackage

// File: rtl/matrix_row_buffer.sv
// 4x4 word store for one incoming matrix. The write index is the arrival
// order of the word; MATRIX_TRANSPOSE_EN selects column-major arrival
// (word k -> row k%4, column k/4) instead of row-major (row k/4, column k%4).
// The read port returns one packed row with column 0 in the top word.
module matrix_row_buffer
   import matrix_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [3:0]          wr_idx,
   input  logic [WORD_W-1:0]   wr_data,
   input  logic [1:0]          rd_row,
   output logic [4*WORD_W-1:0] rd_data
);

   logic [WORD_W-1:0] mem [4][4];
   logic [1:0]        wr_r;
   logic [1:0]        wr_c;

   // Map arrival index onto a (row, column) cell.
   always_comb begin
`ifdef MATRIX_TRANSPOSE_EN
      wr_r = wr_idx[1:0];
      wr_c = wr_idx[3:2];
`else
      wr_r = wr_idx[3:2];
      wr_c = wr_idx[1:0];
`endif
   end

   // Word storage; reset clears so no stale words survive an abandoned load.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               mem[r][c] <= '0;
            end
         end
      end else if (wr_en) begin
         mem[wr_r][wr_c] <= wr_data;
      end
   end

   // Row read mux, column 0 in the most significant word.
   always_comb begin
      rd_data = {mem[rd_row][0], mem[rd_row][1], mem[rd_row][2], mem[rd_row][3]};
   end

endmodule

// File: rtl/matrix_cmd_seq.sv
// Matrix command sequencer: turns decoded matrix commands into stack
// controls. LOAD gathers 16 words then issues a gap-free 4-row burst;
// LOAD_ID/PUSH/POP become one-cycle enable pulses. Optional build macro
// MATRIX_TRANSPOSE_EN (in matrix_row_buffer) accepts column-major words.
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high; ready never depends on valid, and valid may rise at any time.
module matrix_cmd_seq
   import matrix_pkg::*;
#(
   parameter int WORD_W  = 32,
   parameter int N_WORDS = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                fifo_full,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [2:0]          cmd_op,
   input  logic                cmd_mode,
   input  logic                word_valid,
   output logic                word_ready,
   input  logic [WORD_W-1:0]   word_data,
   output logic                matrix_mode,
   output logic                load_en,
   output logic                load_id_en,
   output logic                push_en,
   output logic                pop_en,
   output logic [4*WORD_W-1:0] data_in,
   output logic                busy
);

   localparam logic [3:0] LAST_WORD = 4'(N_WORDS - 1);

   seq_state_t          state, next_state;
   logic [3:0]          word_cnt;
   logic [1:0]          row_cnt;
   logic [2:0]          op_q;
   logic                mode_q;
   logic [4*WORD_W-1:0] row_data;

   logic                cmd_ready_c, word_ready_c;
   logic                load_en_c, load_id_en_c, push_en_c, pop_en_c;
   logic [4*WORD_W-1:0] data_c;
   logic                cmd_accept, word_accept;

   matrix_row_buffer #(.WORD_W(WORD_W)) u_row_buffer (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (word_accept),
      .wr_idx  (word_cnt),
      .wr_data (word_data),
      .rd_row  (row_cnt),
      .rd_data (row_data)
   );

   // Next-state and raw output decode.
   always_comb begin
      next_state   = state;
      cmd_ready_c  = 1'b0;
      word_ready_c = 1'b0;
      load_en_c    = 1'b0;
      load_id_en_c = 1'b0;
      push_en_c    = 1'b0;
      pop_en_c     = 1'b0;
      data_c       = '0;
      case (state)
         ST_IDLE: begin
            cmd_ready_c = !fifo_full;
            if (cmd_valid && cmd_ready_c) begin
               case (cmd_op)
                  OP_LOAD:                   next_state = ST_COLLECT;
                  OP_LOAD_ID, OP_PUSH, OP_POP: next_state = ST_PULSE;
                  default:                   next_state = ST_IDLE;
               endcase
            end
         end
         ST_COLLECT: begin
            word_ready_c = 1'b1;
            if (word_valid && word_cnt == LAST_WORD) next_state = ST_BURST;
         end
         ST_BURST: begin
            // The stack cannot pause mid-load, so fifo_full is ignored here.
            data_c    = row_data;
            load_en_c = (row_cnt == 2'd0);
            if (row_cnt == 2'd3) next_state = ST_IDLE;
         end
         ST_PULSE: begin
            load_id_en_c = (op_q == OP_LOAD_ID);
            push_en_c    = (op_q == OP_PUSH);
            pop_en_c     = (op_q == OP_POP);
            next_state   = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   assign cmd_accept  = cmd_valid && cmd_ready_c;
   assign word_accept = word_valid && word_ready_c;

   // State, counters and latched command fields.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         word_cnt <= '0;
         row_cnt  <= '0;
         op_q     <= OP_NOP;
         mode_q   <= MODE_MODELVIEW;
      end else begin
         state <= next_state;
         if (cmd_accept) begin
            op_q     <= cmd_op;
            mode_q   <= cmd_mode;
            word_cnt <= '0;
         end else if (word_accept) begin
            word_cnt <= word_cnt + 4'd1;
         end
         if (state == ST_BURST) row_cnt <= row_cnt + 2'd1;
         else                   row_cnt <= '0;
      end
   end

   // Outputs forced to zero while reset is asserted.
   always_comb begin
      cmd_ready   = !reset && cmd_ready_c;
      word_ready  = !reset && word_ready_c;
      load_en     = !reset && load_en_c;
      load_id_en  = !reset && load_id_en_c;
      push_en     = !reset && push_en_c;
      pop_en      = !reset && pop_en_c;
      matrix_mode = !reset && mode_q;
      busy        = !reset && (state != ST_IDLE);
      data_in     = reset ? '0 : data_c;
   end

endmodule

// File: tb/tb_matrix_cmd_seq.sv
// Bench for matrix_cmd_seq: directed scenarios plus random commands, with a
// queue-based behavioural model checked against every output on every cycle.
module tb_matrix_cmd_seq;

   localparam int OBS_W   = 136;
   localparam int FRAME_W = 133;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         fifo_full = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [2:0]   cmd_op = 3'd0;
   logic         cmd_mode = 1'b0;
   logic         word_valid = 1'b0;
   logic         word_ready;
   logic [31:0]  word_data = '0;
   logic         matrix_mode;
   logic         load_en, load_id_en, push_en, pop_en;
   logic [127:0] data_in;
   logic         busy;

   matrix_cmd_seq dut (
      .clk         (clk),
      .reset       (reset),
      .fifo_full   (fifo_full),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_mode    (cmd_mode),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .word_data   (word_data),
      .matrix_mode (matrix_mode),
      .load_en     (load_en),
      .load_id_en  (load_id_en),
      .push_en     (push_en),
      .pop_en      (pop_en),
      .data_in     (data_in),
      .busy        (busy)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [OBS_W-1:0] act, input logic [OBS_W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out", name);
   endtask

   // Behavioural model: pending output frames ({mode, load, load_id, push, pop, row})
   // for cycles where the block is busy issuing, plus a word-gathering flag.
   logic [FRAME_W-1:0] exp_q[$];
   bit                 m_collect = 0;
   int                 m_nwords = 0;
   logic               m_mode = 1'b0;
   logic [31:0]        m_words[16];
   int                 cyc = 0;
   logic [127:0]       cap_rows[4];
   int                 cap_n = 0;

   function automatic logic [127:0] model_row(input int r);
      logic [127:0] row;
      int idx;
      row = '0;
      for (int c = 0; c < 4; c++) begin
`ifdef MATRIX_TRANSPOSE_EN
         idx = c * 4 + r;
`else
         idx = r * 4 + c;
`endif
         row[127-32*c -: 32] = m_words[idx];
      end
      return row;
   endfunction

   // Compare every output each cycle, then advance the model past the next edge.
   always @(negedge clk) begin
      logic [OBS_W-1:0] exp_v, act_v;
      act_v = {cmd_ready, word_ready, busy, matrix_mode, load_en, load_id_en, push_en, pop_en, data_in};
      if (reset)                  exp_v = '0;
      else if (exp_q.size() > 0)  exp_v = {3'b001, exp_q[0]};
      else if (m_collect)         exp_v = {3'b011, m_mode, 4'b0000, 128'h0};
      else                        exp_v = {!fifo_full, 2'b00, m_mode, 4'b0000, 128'h0};
      check($sformatf("cycle %0d outputs", cyc), act_v, exp_v);
      check($sformatf("cycle %0d enables at most one", cyc),
            OBS_W'($countones({load_en, load_id_en, push_en, pop_en}) <= 1), OBS_W'(1));

      if (!reset && load_en) begin
         cap_rows[0] = data_in;
         cap_n = 1;
      end else if (cap_n > 0 && cap_n < 4) begin
         cap_rows[cap_n] = data_in;
         cap_n++;
      end

      if (reset) begin
         exp_q.delete();
         m_collect = 0;
         m_nwords  = 0;
         m_mode    = 1'b0;
      end else if (exp_q.size() > 0) begin
         void'(exp_q.pop_front());
      end else if (m_collect) begin
         if (word_valid) begin
            m_words[m_nwords] = word_data;
            m_nwords++;
            if (m_nwords == 16) begin
               m_collect = 0;
               for (int r = 0; r < 4; r++) exp_q.push_back({m_mode, 1'(r == 0), 3'b000, model_row(r)});
            end
         end
      end else if (cmd_valid && !fifo_full) begin
         m_mode = cmd_mode;
         case (cmd_op)
            3'd1: begin m_collect = 1; m_nwords = 0; end
            3'd2: exp_q.push_back({m_mode, 4'b0100, 128'h0});
            3'd3: exp_q.push_back({m_mode, 4'b0010, 128'h0});
            3'd4: exp_q.push_back({m_mode, 4'b0001, 128'h0});
            default: ;
         endcase
      end
      cyc++;
   end

   // ---------------- driver tasks ----------------
   logic [31:0] drv_words[16];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [2:0] op, input logic mode);
      bit acc = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_mode  = mode;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         acc = cmd_ready;
         step();
      end
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      if (!acc) fail_now("command accept");
   endtask

   // pattern 0: word_valid always high, 1: every other cycle, 2: random
   task automatic send_words(input int n, input int pattern);
      int idx = 0;
      int t = 0;
      bit acc;
      while (idx < n && t < 500) begin
         word_data  = drv_words[idx];
         word_valid = (pattern == 0) ? 1'b1 : (pattern == 1) ? 1'((t % 2) == 0) : 1'($urandom_range(0, 1));
         @(negedge clk);
         acc = word_valid && word_ready;
         step();
         if (acc) idx++;
         t++;
      end
      word_valid = 1'b0;
      if (idx < n) fail_now("word accept");
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         done = !busy;
         if (!done) step();
      end
      if (!done) fail_now("return to idle");
      step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset for three cycles; the compare process expects all-zero outputs.
      repeat (3) step();
      reset = 1'b0;
      @(negedge clk);
      check("idle after reset", {busy, matrix_mode, load_en, data_in}, '0);
      step();

      // 1: identity load, row-major words (symmetric, so same in both builds).
      for (int k = 0; k < 16; k++) drv_words[k] = (k % 5 == 0) ? 32'h3F80_0000 : 32'h0;
      send_cmd(3'd1, 1'b0);
      send_words(16, 0);
      wait_idle();
      check("t1 row0", cap_rows[0], 128'h3F800000_00000000_00000000_00000000);
      check("t1 row1", cap_rows[1], 128'h00000000_3F800000_00000000_00000000);
      check("t1 row2", cap_rows[2], 128'h00000000_00000000_3F800000_00000000);
      check("t1 row3", cap_rows[3], 128'h00000000_00000000_00000000_3F800000);

      // 2: single-cycle ops with alternating modes.
      send_cmd(3'd4, 1'b1);
      @(negedge clk);
      check("t2 pop pulse", {pop_en, matrix_mode}, 2'b11);
      step();
      send_cmd(3'd3, 1'b0);
      send_cmd(3'd2, 1'b1);
      step();

      // 3: counting words with toggling word_valid.
      for (int k = 0; k < 16; k++) drv_words[k] = 32'(k + 1);
      send_cmd(3'd1, 1'b1);
      send_words(16, 1);
      wait_idle();
`ifdef MATRIX_TRANSPOSE_EN
      check("t3 row0", cap_rows[0], 128'h00000001_00000005_00000009_0000000D);
      check("t3 row1", cap_rows[1], 128'h00000002_00000006_0000000A_0000000E);
      check("t3 row2", cap_rows[2], 128'h00000003_00000007_0000000B_0000000F);
      check("t3 row3", cap_rows[3], 128'h00000004_00000008_0000000C_00000010);
`else
      check("t3 row0", cap_rows[0], 128'h00000001_00000002_00000003_00000004);
      check("t3 row1", cap_rows[1], 128'h00000005_00000006_00000007_00000008);
      check("t3 row2", cap_rows[2], 128'h00000009_0000000A_0000000B_0000000C);
      check("t3 row3", cap_rows[3], 128'h0000000D_0000000E_0000000F_00000010);
`endif

      // 4a: fifo_full blocks command start.
      fifo_full = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = 3'd3;
      repeat (5) step();
      @(negedge clk);
      check("t4 stalled", {cmd_ready, push_en, busy}, 3'b000);
      step();
      cmd_valid = 1'b0;
      fifo_full = 1'b0;
      step();

      // 4b: fifo_full raised at burst row 1 must not stall the burst.
      for (int k = 0; k < 16; k++) drv_words[k] = $urandom;
      send_cmd(3'd1, 1'b0);
      send_words(16, 0);
      step();
      fifo_full = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = 3'd3;
      wait_idle();
      cmd_valid = 1'b0;
      fifo_full = 1'b0;
      step();

      // 5: reset after 9 words, then a full fresh load.
      for (int k = 0; k < 16; k++) drv_words[k] = 32'hDEAD_0000 | 32'(k);
      send_cmd(3'd1, 1'b1);
      send_words(9, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      check("t5 after reset", {busy, word_ready, matrix_mode, data_in}, '0);
      step();
      for (int k = 0; k < 16; k++) drv_words[k] = 32'h0100_0000 + 32'(k);
      send_cmd(3'd1, 1'b0);
      send_words(16, 2);
      wait_idle();
      check("t5 row0 fresh", cap_rows[0][127:96], 32'h0100_0000);

      // 6: reserved and NOP ops are consumed silently.
      send_cmd(3'd6, 1'b1);
      @(negedge clk);
      check("t6 reserved", {busy, load_en, load_id_en, push_en, pop_en}, 5'b0);
      step();
      send_cmd(3'd0, 1'b0);

      // Random traffic.
      for (int it = 0; it < 40; it++) begin
         logic [2:0] op;
         op = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) begin
            fifo_full = 1'b1;
            cmd_valid = 1'b1;
            cmd_op    = op;
            repeat ($urandom_range(1, 3)) step();
            fifo_full = 1'b0;
         end
         send_cmd(op, 1'($urandom_range(0, 1)));
         if (op == 3'd1) begin
            for (int k = 0; k < 16; k++) drv_words[k] = $urandom;
            send_words(16, 2);
         end
         wait_idle();
      end

      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog in case a task loop misbehaves.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
